// File: rtl/traffic_light_monitor.sv
// Passive lamp-bus checker for the traffic light controller.
// Tracks phase/dwell and latches the first fault seen.
module traffic_light_monitor #(
  parameter int MIN_L0    = 10,
  parameter int MIN_L1    = 2,
  parameter int MIN_L2    = 8,
  parameter int MAX_DWELL = 200
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       en,
  input  logic [3:0] lamp,
  input  logic       clr,
  output logic [1:0] phase,
  output logic [7:0] dwell,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [7:0] fault_cnt
);

  localparam logic [3:0] L0 = 4'b1000;
  localparam logic [3:0] L1 = 4'b0100;
  localparam logic [3:0] L2 = 4'b0010;
  localparam logic [7:0] MIN0 = 8'(MIN_L0);
  localparam logic [7:0] MIN1 = 8'(MIN_L1);
  localparam logic [7:0] MIN2 = 8'(MIN_L2);
  localparam logic [7:0] MAXD_M1 = 8'(MAX_DWELL - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t     state_q, state_d;
  logic [1:0] phase_d;
  logic [7:0] dwell_d;
  logic       ev;
  logic [2:0] ev_code;
  logic       is_ph;
  logic [1:0] ph;
  logic [7:0] min_sel;
  logic       step_ok;

  always_comb begin
    is_ph = 1'b1;
    ph    = 2'd0;
    unique case (1'b1)
      (lamp == L0): ph = 2'd0;
      (lamp == L1): ph = 2'd1;
      (lamp == L2): ph = 2'd2;
      default:      is_ph = 1'b0;
    endcase
  end

  always_comb begin
    min_sel = MIN0;
    unique case (1'b1)
      (phase == 2'd1): min_sel = MIN1;
      (phase == 2'd2): min_sel = MIN2;
      default:         min_sel = MIN0;
    endcase
  end

  // Any phase may drop to L0; otherwise only one step forward.
  assign step_ok = (ph == 2'd0) || (ph == phase + 2'd1);

  always_comb begin
    state_d = state_q;
    phase_d = phase;
    dwell_d = dwell;
    ev      = 1'b0;
    ev_code = 3'd0;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          if (is_ph) begin
            state_d = RUN;
            phase_d = ph;
            dwell_d = 8'd1;
          end else begin
            ev      = 1'b1;
            ev_code = 3'd1;
          end
        end
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
          phase_d = 2'd3;
          dwell_d = 8'd0;
        end else if (!is_ph) begin
          ev      = 1'b1;
          ev_code = 3'd1;
          state_d = IDLE;
          phase_d = 2'd3;
          dwell_d = 8'd0;
        end else if (ph == phase) begin
          if (dwell != 8'hff) dwell_d = dwell + 8'd1;
          if (dwell == MAXD_M1) begin
            ev      = 1'b1;
            ev_code = 3'd4;
          end
        end else begin
          phase_d = ph;
          dwell_d = 8'd1;
          if (!step_ok) begin
            ev      = 1'b1;
            ev_code = 3'd2;
          end else if (ph != 2'd0 && dwell < min_sel) begin
            ev      = 1'b1;
            ev_code = 3'd3;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q    <= IDLE;
      phase      <= 2'd3;
      dwell      <= 8'd0;
      fault      <= 1'b0;
      fault_code <= 3'd0;
      fault_cnt  <= 8'd0;
    end else begin
      state_q <= state_d;
      phase   <= phase_d;
      dwell   <= dwell_d;
      if (ev) begin
        fault <= 1'b1;
        if (clr || fault_code == 3'd0) fault_code <= ev_code;
        if (clr) fault_cnt <= 8'd1;
        else if (fault_cnt != 8'hff) fault_cnt <= fault_cnt + 8'd1;
      end else if (clr) begin
        fault      <= 1'b0;
        fault_code <= 3'd0;
        fault_cnt  <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor.
// obs packs {phase, dwell, fault, fault_code, fault_cnt}.
module tb_traffic_light_monitor;

  localparam logic [3:0] L0 = 4'b1000;
  localparam logic [3:0] L1 = 4'b0100;
  localparam logic [3:0] L2 = 4'b0010;

  logic       clk = 1'b0;
  logic       res_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] lamp = 4'b0000;
  logic       clr = 1'b0;
  logic [1:0] phase;
  logic [7:0] dwell;
  logic       fault;
  logic [2:0] fault_code;
  logic [7:0] fault_cnt;
  logic [21:0] obs;
  logic [21:0] exp_v;
  int checks = 0;
  int errors = 0;

  traffic_light_monitor #(
    .MIN_L0(10), .MIN_L1(2), .MIN_L2(8), .MAX_DWELL(200)
  ) dut (
    .clk(clk), .res_n(res_n), .en(en), .lamp(lamp), .clr(clr),
    .phase(phase), .dwell(dwell), .fault(fault),
    .fault_code(fault_code), .fault_cnt(fault_cnt)
  );

  always #5 clk = ~clk;

  assign obs = {phase, dwell, fault, fault_code, fault_cnt};

  task automatic step(input logic [3:0] l, input int n);
    for (int i = 0; i < n; i++) begin
      lamp = l;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    res_n = 1'b0;
    en = 1'b0;
    clr = 1'b0;
    lamp = 4'b0000;
    @(posedge clk);
    #1;
    res_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    exp_v = {2'd3, 8'd0, 1'b0, 3'd0, 8'd0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reset got %h exp %h", obs, exp_v);
    end
  endtask

  task automatic test_normal();
    do_reset();
    en = 1'b1;
    step(L0, 10);
    exp_v = {2'd0, 8'd10, 1'b0, 3'd0, 8'd0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL norm_l0 got %h exp %h", obs, exp_v);
    end
    step(L1, 2);
    exp_v = {2'd1, 8'd2, 1'b0, 3'd0, 8'd0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL norm_l1 got %h exp %h", obs, exp_v);
    end
    step(L2, 8);
    exp_v = {2'd2, 8'd8, 1'b0, 3'd0, 8'd0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL norm_l2 got %h exp %h", obs, exp_v);
    end
    step(L0, 1);
    exp_v = {2'd0, 8'd1, 1'b0, 3'd0, 8'd0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL norm_wrap got %h exp %h", obs, exp_v);
    end
    en = 1'b0;
    step(4'b1111, 1);
    exp_v = {2'd3, 8'd0, 1'b0, 3'd0, 8'd0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL norm_dis got %h exp %h", obs, exp_v);
    end
  endtask

  task automatic test_order();
    do_reset();
    en = 1'b1;
    step(L0, 10);
    step(L2, 1);
    exp_v = {2'd2, 8'd1, 1'b1, 3'd2, 8'd1};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL order got %h exp %h", obs, exp_v);
    end
    step(4'b0000, 1);
    exp_v = {2'd3, 8'd0, 1'b1, 3'd2, 8'd2};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL order_hold got %h exp %h", obs, exp_v);
    end
  endtask

  task automatic test_min_dwell();
    do_reset();
    en = 1'b1;
    step(L0, 10);
    step(L1, 1);
    exp_v = {2'd1, 8'd1, 1'b0, 3'd0, 8'd0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL min_pre got %h exp %h", obs, exp_v);
    end
    step(L2, 1);
    exp_v = {2'd2, 8'd1, 1'b1, 3'd3, 8'd1};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL min_short got %h exp %h", obs, exp_v);
    end
    step(L2, 3);
    step(L0, 1);
    exp_v = {2'd0, 8'd1, 1'b1, 3'd3, 8'd1};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL min_override got %h exp %h", obs, exp_v);
    end
  endtask

  task automatic test_disabled_code();
    do_reset();
    en = 1'b1;
    step(4'b1111, 1);
    exp_v = {2'd3, 8'd0, 1'b1, 3'd1, 8'd1};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL dis_code got %h exp %h", obs, exp_v);
    end
    step(L1, 1);
    exp_v = {2'd1, 8'd1, 1'b1, 3'd1, 8'd1};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL dis_start got %h exp %h", obs, exp_v);
    end
  endtask

  task automatic test_stuck();
    do_reset();
    en = 1'b1;
    step(L1, 199);
    exp_v = {2'd1, 8'd199, 1'b0, 3'd0, 8'd0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL stuck_pre got %h exp %h", obs, exp_v);
    end
    step(L1, 1);
    exp_v = {2'd1, 8'd200, 1'b1, 3'd4, 8'd1};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL stuck_fire got %h exp %h", obs, exp_v);
    end
    step(L1, 55);
    exp_v = {2'd1, 8'd255, 1'b1, 3'd4, 8'd1};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL stuck_sat got %h exp %h", obs, exp_v);
    end
    step(L1, 5);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL stuck_hold got %h exp %h", obs, exp_v);
    end
  endtask

  task automatic test_clr();
    clr = 1'b1;
    step(4'b0000, 1);
    exp_v = {2'd3, 8'd0, 1'b1, 3'd1, 8'd1};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL clr_event got %h exp %h", obs, exp_v);
    end
    en = 1'b0;
    step(4'b1111, 1);
    exp_v = {2'd3, 8'd0, 1'b0, 3'd0, 8'd0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL clr_only got %h exp %h", obs, exp_v);
    end
    clr = 1'b0;
    en = 1'b1;
    step(4'b0000, 1);
    step(L0, 3);
    exp_v = {2'd0, 8'd3, 1'b1, 3'd1, 8'd1};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL clr_run got %h exp %h", obs, exp_v);
    end
    #2;
    res_n = 1'b0;
    #1;
    exp_v = {2'd3, 8'd0, 1'b0, 3'd0, 8'd0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL async_rst got %h exp %h", obs, exp_v);
    end
    @(posedge clk);
    #1;
    res_n = 1'b1;
    step(L2, 1);
    exp_v = {2'd2, 8'd1, 1'b0, 3'd0, 8'd0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL rst_restart got %h exp %h", obs, exp_v);
    end
  endtask

  task automatic test_cnt_sat();
    do_reset();
    en = 1'b1;
    step(4'b0001, 254);
    exp_v = {2'd3, 8'd0, 1'b1, 3'd1, 8'd254};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL cnt_254 got %h exp %h", obs, exp_v);
    end
    step(4'b0110, 3);
    exp_v = {2'd3, 8'd0, 1'b1, 3'd1, 8'd255};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL cnt_sat got %h exp %h", obs, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_order();
    test_min_dwell();
    test_disabled_code();
    test_stuck();
    test_clr();
    test_cnt_sat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Passive checker on the lamp bus of the traffic light controller. It samples the controller's 4-bit lamp output every clock and tracks the active phase and how long it has been held. It latches a sticky fault when it sees an illegal lamp code, an illegal phase order, a phase held shorter than its minimum, or a phase held too long. It sits beside the controller, and the fault output feeds the intersection's flash-red override logic.

## Interface
- `MIN_L0`, default 10: minimum dwell in cycles for phase L0 (lamp 4'b1000).
- `MIN_L1`, default 2: minimum dwell for phase L1 (lamp 4'b0100).
- `MIN_L2`, default 8: minimum dwell for phase L2 (lamp 4'b0010).
- `MAX_DWELL`, default 200: dwell count at which any phase is declared stuck. Must satisfy 1 ≤ MAX_DWELL ≤ 255.
- `clk` in 1: single clock, rising edge.
- `res_n` in 1: asynchronous, active-low reset.
- `en` in 1: monitor enable, tied to the controller's enable.
- `lamp` in 4: controller lamp output.
- `clr` in 1: synchronous clear of `fault`, `fault_code` and `fault_cnt`.
- `phase` out 2: current phase, 0/1/2 for L0/L1/L2, 3 when not tracking.
- `dwell` out 8: cycles the current phase has been held, saturates at 255.
- `fault` out 1: sticky fault flag.
- `fault_code` out 3: code of the first fault since reset or clear; 0 means none.
- `fault_cnt` out 8: count of fault events, saturates at 255.

## Operation
- Legal codes:
  - L0 = 4'b1000, L1 = 4'b0100, L2 = 4'b0010.
  - 4'b1111 is the disabled pattern. It is legal only while `en` = 0.
  - Every other code is illegal.
- Legal transitions are L0→L1, L1→L2, L2→L0, and any phase→L0 (override to stop).
- Two states:
  - IDLE: `phase` = 3, `dwell` = 0.
  - RUN: tracking a phase.
- IDLE behaviour:
  - `en` = 0: stay in IDLE and ignore `lamp`.
  - `en` = 1 with `lamp` = L0/L1/L2: go to RUN, load `phase`, set `dwell` = 1. No order or dwell check is made on this first sample.
  - `en` = 1 with an illegal code (including 4'b1111): raise fault code 1 and stay in IDLE.
- RUN behaviour, evaluated every cycle:
  - `en` = 0: go to IDLE. No fault.
  - `lamp` illegal: fault code 1, go to IDLE.
  - `lamp` equals the current phase: `dwell`++ (saturating). When `dwell` goes from MAX_DWELL−1 to MAX_DWELL, raise fault code 4. This fires once per phase occupancy.
  - `lamp` is a different legal phase:
    - If the transition is illegal, fault code 2.
    - Otherwise, if the new phase is not L0 and the old `dwell` < MIN of the old phase, fault code 3. Overrides into L0 are exempt from the minimum-dwell check.
    - In both cases load the new `phase` and set `dwell` = 1.
- Fault event handling:
  - At most one event per cycle. If several conditions hold, the lowest code wins.
  - On an event: `fault` = 1 and `fault_cnt`++ (saturating at 255).
  - `fault_code` is written only if it is currently 0, so the first fault is held.
- `clr`:
  - Sets `fault` = 0, `fault_code` = 0, `fault_cnt` = 0.
  - If an event occurs in the same cycle, the event wins: `fault` = 1, `fault_code` = new code, `fault_cnt` = 1.
  - `clr` does not affect `phase` or `dwell`.

## Timing
- All outputs are registered. A fault on a sampled `lamp` value is visible right after the same rising edge that samples it, i.e. zero cycles of added latency relative to the sample.
- Reset (asynchronous on `res_n` low) forces IDLE, `phase` = 3, `dwell` = 0, `fault` = 0, `fault_code` = 0, `fault_cnt` = 0. Release is recognised at the next edge.
- Reset during RUN or with a fault latched clears everything. After release, tracking restarts with no transition check on the first sample.
- `dwell` semantics: `dwell` = N after the N-th consecutive edge sampling the same phase. A phase held for exactly MIN cycles passes the minimum-dwell check.
- Once `dwell` reaches 255 it holds there. The stuck fault is not repeated.

## Test plan
- Reset, then `en` = 1 with L0 ×10, L1 ×2, L2 ×8, L0 → `phase` sequence 0,1,2,0; `dwell` peaks 10/2/8; `fault` = 0 throughout.
- L0 ×10 then L2 → fault code 2, `fault_cnt` = 1, `phase` = 2, `dwell` = 1.
- L0 ×10, L1 ×1, L2 → fault code 3. Then L2 ×3 followed by L0 → no new fault (override exempt); `fault_code` stays 3, `fault_cnt` = 1.
- `en` = 1 with `lamp` = 4'b1111 → fault code 1 with `phase` = 3. Then L1 → RUN, `phase` = 1, `dwell` = 1.
- L1 held 200 cycles with MAX_DWELL = 200 → fault code 4 on cycle 200 only; `fault_cnt` = 1 and `dwell` continues to 255 and holds.
- With a fault latched, assert `clr` in the same cycle as an illegal code → `fault` = 1, `fault_code` = 1, `fault_cnt` = 1. Then pulse `res_n` low mid-RUN → all outputs return to reset values immediately.
